// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, field lengths and address constants for the Ethernet header capture block
package eth_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_DISCARD} state_t;
  localparam logic [15:0] ETH_TYPE_MIN = 16'h0600;
  localparam logic [47:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int DST_LEN = 6;
  localparam int SRC_LEN = 6;
  localparam int TL_LEN = 2;
endpackage

// File: rtl/eth_header_capture_if.sv
// eth_header_capture_if: byte stream, field strobes and captured-header/payload outputs
// i_enable/i_data/i_*_valid: upstream header FSM stream; o_*: captured fields, payload stream, status pulses
interface eth_header_capture_if;
  logic        i_enable;
  logic [7:0]  i_data;
  logic        i_preamble_valid;
  logic        i_dst_addr_valid;
  logic        i_src_addr_valid;
  logic        i_type_length_valid;
  logic [47:0] o_dst_addr;
  logic [47:0] o_src_addr;
  logic [15:0] o_type_length;
  logic        o_header_done;
  logic        o_addr_match;
  logic        o_is_broadcast;
  logic        o_payload_valid;
  logic [7:0]  o_payload_data;
  logic        o_payload_last;
  logic        o_frame_error;
  modport master (
    output i_enable, i_data, i_preamble_valid, i_dst_addr_valid, i_src_addr_valid, i_type_length_valid,
    input  o_dst_addr, o_src_addr, o_type_length, o_header_done, o_addr_match, o_is_broadcast,
           o_payload_valid, o_payload_data, o_payload_last, o_frame_error
  );
  modport slave (
    input  i_enable, i_data, i_preamble_valid, i_dst_addr_valid, i_src_addr_valid, i_type_length_valid,
    output o_dst_addr, o_src_addr, o_type_length, o_header_done, o_addr_match, o_is_broadcast,
           o_payload_valid, o_payload_data, o_payload_last, o_frame_error
  );
endinterface

// File: rtl/eth_field_shift.sv
// eth_field_shift: N-byte shift-in capture register with a byte counter and field-complete flag
// i_clr restarts the count, i_load shifts i_data in at [7:0], o_done marks the load that completes the field
module eth_field_shift #(
  parameter int W = 48,
  parameter int N = 6
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [7:0]   i_data,
  output logic [W-1:0] o_value,
  output logic         o_done
);
  logic [W-1:0] r_value;
  logic [2:0]   r_cnt;
  assign o_value = r_value;
  assign o_done  = i_load && r_cnt == 3'(N - 1);
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load) r_value <= {r_value[W-9:0], i_data};
      r_cnt <= (i_clr || o_done) ? 3'd0 : i_load ? r_cnt + 3'd1 : r_cnt;
    end
  end
endmodule

// File: rtl/eth_header_capture.sv
// eth_header_capture: captures DST/SRC/Type-Length, filters on destination and forwards length-bounded payload
// i_clock/i_reset: clock and async active-high reset; bus: slave side of eth_header_capture_if
module eth_header_capture
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR    = 48'h010203040506,
  parameter bit          PROMISCUOUS = 1'b0,
  parameter int          MAX_LEN     = 1500
) (
  input logic i_clock,
  input logic i_reset,
  eth_header_capture_if.slave bus
);
  state_t      r_state, w_next;
  logic [47:0] w_dst, w_src;
  logic [15:0] w_tl, w_tl_new;
  logic        w_dst_done, w_src_done, w_tl_done;
  logic        w_pre, w_dst_ok, w_src_ok, w_tl_ok, w_ld_dst, w_ld_src, w_ld_tl;
  logic        w_match, w_type, w_bad, w_len_end;
  logic        w_hd, w_pv, w_pl, w_err;
  logic        r_hd, r_am, r_bc, r_pv, r_pl, r_fe, r_bad, r_len_mode;
  logic [7:0]  r_pd;
  logic [10:0] r_len, r_cnt;
  assign w_pre    = bus.i_preamble_valid;
  // a header byte is only legal with enable high and exactly its own strobe
  assign w_dst_ok = bus.i_enable & bus.i_dst_addr_valid & ~bus.i_src_addr_valid & ~bus.i_type_length_valid;
  assign w_src_ok = bus.i_enable & ~bus.i_dst_addr_valid & bus.i_src_addr_valid & ~bus.i_type_length_valid;
  assign w_tl_ok  = bus.i_enable & ~bus.i_dst_addr_valid & ~bus.i_src_addr_valid & bus.i_type_length_valid;
  assign w_ld_dst = ~w_pre & (r_state == S_DST) & w_dst_ok;
  assign w_ld_src = ~w_pre & (r_state == S_SRC) & w_src_ok;
  assign w_ld_tl  = ~w_pre & (r_state == S_TYPE) & w_tl_ok;
  // decisions at the last Type/Length byte use the value about to be registered
  assign w_tl_new  = {w_tl[7:0], bus.i_data};
  assign w_match   = PROMISCUOUS | (w_dst == MAC_ADDR) | (w_dst == BROADCAST_ADDR);
  assign w_type    = w_tl_new >= ETH_TYPE_MIN;
  assign w_bad     = w_tl_done & ~w_type & (w_tl_new > 16'(MAX_LEN));
  assign w_len_end = r_len_mode & (r_cnt + 11'd1 == r_len);
  eth_field_shift #(.W(8 * DST_LEN), .N(DST_LEN)) u_dst (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(w_pre), .i_load(w_ld_dst), .i_data(bus.i_data),
    .o_value(w_dst), .o_done(w_dst_done)
  );
  eth_field_shift #(.W(8 * SRC_LEN), .N(SRC_LEN)) u_src (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(w_pre), .i_load(w_ld_src), .i_data(bus.i_data),
    .o_value(w_src), .o_done(w_src_done)
  );
  eth_field_shift #(.W(8 * TL_LEN), .N(TL_LEN)) u_tl (
    .i_clock(i_clock), .i_reset(i_reset), .i_clr(w_pre), .i_load(w_ld_tl), .i_data(bus.i_data),
    .o_value(w_tl), .o_done(w_tl_done)
  );
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_pre) w_next = S_DST;
    else
      case (r_state)
        S_DST:     w_next = !w_dst_ok ? S_IDLE : w_dst_done ? S_SRC : S_DST;
        S_SRC:     w_next = !w_src_ok ? S_IDLE : w_src_done ? S_TYPE : S_SRC;
        S_TYPE:    w_next = !w_tl_ok ? S_IDLE : !w_tl_done ? S_TYPE :
                            (w_match && w_tl_new != 16'h0 && !w_bad) ? S_PAYLOAD : S_DISCARD;
        S_PAYLOAD: w_next = !bus.i_enable ? S_IDLE : w_len_end ? S_DISCARD : S_PAYLOAD;
        S_DISCARD: w_next = bus.i_enable ? S_DISCARD : S_IDLE;
        default:   w_next = S_IDLE;
      endcase
  end
  // r_bad delays the illegal-length error by one cycle so it follows header_done
  always_comb begin
    w_hd  = w_tl_done;
    w_pv  = ~w_pre & (r_state == S_PAYLOAD) & bus.i_enable;
    w_pl  = w_pv & w_len_end;
    w_err = ~w_pre & (((r_state == S_DST) & ~w_dst_ok) | ((r_state == S_SRC) & ~w_src_ok) |
                      ((r_state == S_TYPE) & ~w_tl_ok) |
                      ((r_state == S_PAYLOAD) & ~bus.i_enable & r_len_mode) | r_bad);
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hd       <= 1'b0;
      r_am       <= 1'b0;
      r_bc       <= 1'b0;
      r_pv       <= 1'b0;
      r_pl       <= 1'b0;
      r_fe       <= 1'b0;
      r_bad      <= 1'b0;
      r_pd       <= '0;
      r_len_mode <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
    end else begin
      r_hd  <= w_hd;
      r_pv  <= w_pv;
      r_pl  <= w_pl;
      r_fe  <= w_err;
      r_bad <= w_bad;
      if (w_pv) r_pd <= bus.i_data;
      if (w_pre) begin
        r_am <= 1'b0;
        r_bc <= 1'b0;
      end else if (w_tl_done) begin
        r_am <= w_match;
        r_bc <= w_dst == BROADCAST_ADDR;
      end
      if (w_tl_done) begin
        r_len_mode <= ~w_type;
        r_len      <= w_tl_new[10:0];
      end
      r_cnt <= w_tl_done ? 11'd0 : w_pv ? r_cnt + 11'd1 : r_cnt;
    end
  end
  assign bus.o_dst_addr      = w_dst;
  assign bus.o_src_addr      = w_src;
  assign bus.o_type_length   = w_tl;
  assign bus.o_header_done   = r_hd;
  assign bus.o_addr_match    = r_am;
  assign bus.o_is_broadcast  = r_bc;
  assign bus.o_payload_valid = r_pv;
  assign bus.o_payload_data  = r_pd;
  assign bus.o_payload_last  = r_pl;
  assign bus.o_frame_error   = r_fe;
endmodule

// File: tb/tb_eth_header_capture.sv
// tb_eth_header_capture: frame-level model with per-cycle comparison plus literal checks
module tb_eth_header_capture;
  localparam logic [47:0] MAC  = 48'h010203040506;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRCA = 48'hFFFEFDFCFBFA;
  localparam int          MAXL = 1500;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  eth_header_capture_if bus();
  eth_header_capture #(.MAC_ADDR(MAC), .PROMISCUOUS(1'b0), .MAX_LEN(MAXL)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus.slave)
  );
  typedef struct packed {
    logic hd, am, bc, chk, pv, pl, fe;
    logic [7:0] pd;
    logic [47:0] dst, src;
    logic [15:0] tl;
  } exp_t;
  exp_t cur, nx;
  logic pend_fe;
  bit   run = 1'b0;
  int   n_tests = 0, n_fail = 0, pv_cnt = 0, pl_cnt = 0, fe_cnt = 0, hd_cnt = 0;
  int   b_pv, b_pl, b_fe, b_hd;
  function void chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endfunction
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("header_done", 64'(bus.o_header_done), 64'(cur.hd));
      chk("payload_valid", 64'(bus.o_payload_valid), 64'(cur.pv));
      chk("payload_last", 64'(bus.o_payload_last), 64'(cur.pl));
      chk("frame_error", 64'(bus.o_frame_error), 64'(cur.fe));
      chk("dst_addr", 64'(bus.o_dst_addr), 64'(cur.dst));
      chk("src_addr", 64'(bus.o_src_addr), 64'(cur.src));
      chk("type_length", 64'(bus.o_type_length), 64'(cur.tl));
      if (cur.pv) chk("payload_data", 64'(bus.o_payload_data), 64'(cur.pd));
      if (cur.chk) begin
        chk("addr_match", 64'(bus.o_addr_match), 64'(cur.am));
        chk("is_broadcast", 64'(bus.o_is_broadcast), 64'(cur.bc));
      end
      pv_cnt += bus.o_payload_valid ? 1 : 0;
      pl_cnt += bus.o_payload_last ? 1 : 0;
      fe_cnt += bus.o_frame_error ? 1 : 0;
      hd_cnt += bus.o_header_done ? 1 : 0;
    end
  end
  task automatic step(input logic en, input logic [7:0] d, input logic pre, input logic ds, input logic ss, input logic ts);
    @(posedge clk);
    cur = nx;
    nx.hd = 1'b0;
    nx.pv = 1'b0;
    nx.pl = 1'b0;
    nx.fe = pend_fe;
    pend_fe = 1'b0;
    #1;
    bus.i_enable = en;
    bus.i_data = d;
    bus.i_preamble_valid = pre;
    bus.i_dst_addr_valid = ds;
    bus.i_src_addr_valid = ss;
    bus.i_type_length_valid = ts;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic sfd();
    step(1'b1, 8'hD5, 1'b1, 1'b0, 1'b0, 1'b0);
    nx.chk = 1'b0;
  endtask
  task automatic hdr_byte(input int fld, input logic [7:0] x);
    step(1'b1, x, 1'b0, fld == 0, fld == 1, fld == 2);
    if (fld == 0) nx.dst = {nx.dst[39:0], x};
    else if (fld == 1) nx.src = {nx.src[39:0], x};
    else nx.tl = {nx.tl[7:0], x};
  endtask
  task automatic frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int n, input logic [7:0] b0, input bit tail);
    logic m, ty, ln;
    int f;
    sfd();
    for (int i = 0; i < 6; i++) hdr_byte(0, d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) hdr_byte(1, s[47-8*i -: 8]);
    for (int i = 0; i < 2; i++) hdr_byte(2, t[15-8*i -: 8]);
    m  = (d == MAC) || (d == BC);
    ty = t >= 16'h0600;
    ln = t != 16'h0 && int'(t) <= MAXL;
    nx.hd = 1'b1;
    nx.chk = 1'b1;
    nx.am = m;
    nx.bc = d == BC;
    if (!ty && !ln && t != 16'h0) pend_fe = 1'b1;
    f = !m ? 0 : ty ? n : ln ? (n < int'(t) ? n : int'(t)) : 0;
    for (int k = 0; k < n; k++) begin
      step(1'b1, 8'(int'(b0) + k), 1'b0, 1'b0, 1'b0, 1'b0);
      if (k < f) begin
        nx.pv = 1'b1;
        nx.pd = 8'(int'(b0) + k);
        nx.pl = ln && k == int'(t) - 1;
      end
    end
    if (tail) begin
      idle(1);
      if (m && ln && n < int'(t)) nx.fe = 1'b1;
      idle(2);
    end
  endtask
  task automatic bad_hdr(input int nd, input logic en, input logic ds, input logic ss, input logic ts);
    sfd();
    for (int i = 0; i < nd; i++) hdr_byte(0, 8'(8'h30 + i));
    step(en, 8'h77, 1'b0, ds, ss, ts);
    nx.fe = 1'b1;
    idle(3);
  endtask
  task automatic snap();
    b_pv = pv_cnt;
    b_pl = pl_cnt;
    b_fe = fe_cnt;
    b_hd = hd_cnt;
  endtask
  task automatic chk_cnt(input string nm, input int pv, input int pl, input int fe, input int hd);
    chk({nm, "_pv_count"}, 64'(pv_cnt - b_pv), 64'(pv));
    chk({nm, "_last_count"}, 64'(pl_cnt - b_pl), 64'(pl));
    chk({nm, "_err_count"}, 64'(fe_cnt - b_fe), 64'(fe));
    chk({nm, "_hd_count"}, 64'(hd_cnt - b_hd), 64'(hd));
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_dst"}, 64'(bus.o_dst_addr), 64'h0);
    chk({nm, "_src"}, 64'(bus.o_src_addr), 64'h0);
    chk({nm, "_tl"}, 64'(bus.o_type_length), 64'h0);
    chk({nm, "_flags"}, 64'({bus.o_header_done, bus.o_addr_match, bus.o_is_broadcast, bus.o_payload_valid,
                             bus.o_payload_last, bus.o_frame_error}), 64'h0);
    chk({nm, "_pd"}, 64'(bus.o_payload_data), 64'h0);
  endtask
  initial begin
    bus.i_enable = 1'b0;
    bus.i_data = 8'h00;
    bus.i_preamble_valid = 1'b0;
    bus.i_dst_addr_valid = 1'b0;
    bus.i_src_addr_valid = 1'b0;
    bus.i_type_length_valid = 1'b0;
    nx = '0;
    cur = '0;
    pend_fe = 1'b0;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    snap();
    frame(MAC, SRCA, 16'h0800, 4, 8'hAA, 1'b1);
    chk("t1_dst", 64'(bus.o_dst_addr), 64'h010203040506);
    chk("t1_src", 64'(bus.o_src_addr), 64'hFFFEFDFCFBFA);
    chk("t1_tl", 64'(bus.o_type_length), 64'h0800);
    chk("t1_match", 64'(bus.o_addr_match), 64'h1);
    chk_cnt("t1", 4, 0, 0, 1);
    snap();
    frame(BC, SRCA, 16'h0003, 6, 8'h10, 1'b1);
    chk("t2_bcast", 64'(bus.o_is_broadcast), 64'h1);
    chk_cnt("t2", 3, 1, 0, 1);
    snap();
    frame(48'h010203040507, SRCA, 16'h0800, 4, 8'h50, 1'b1);
    chk("t3_match", 64'(bus.o_addr_match), 64'h0);
    chk_cnt("t3", 0, 0, 0, 1);
    snap();
    bad_hdr(4, 1'b1, 1'b0, 1'b0, 1'b0);
    bad_hdr(6, 1'b1, 1'b0, 1'b0, 1'b1);
    bad_hdr(2, 1'b1, 1'b1, 1'b1, 1'b0);
    bad_hdr(3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("t4", 0, 0, 4, 0);
    frame(MAC, SRCA, 16'h0800, 2, 8'hC0, 1'b1);
    chk("t4_recap_dst", 64'(bus.o_dst_addr), 64'h010203040506);
    snap();
    frame(MAC, SRCA, 16'h0010, 5, 8'h60, 1'b1);
    chk_cnt("t5", 5, 0, 1, 1);
    snap();
    frame(MAC, SRCA, 16'h0800, 3, 8'h70, 1'b0);
    frame(MAC, 48'h0A0B0C0D0E0F, 16'h0801, 2, 8'h80, 1'b1);
    chk("t6_src", 64'(bus.o_src_addr), 64'h0A0B0C0D0E0F);
    chk("t6_tl", 64'(bus.o_type_length), 64'h0801);
    chk_cnt("t6", 5, 0, 0, 2);
    snap();
    frame(MAC, SRCA, 16'h0000, 3, 8'h90, 1'b1);
    chk_cnt("t7", 0, 0, 0, 1);
    snap();
    frame(MAC, SRCA, 16'h05DD, 2, 8'hA0, 1'b1);
    frame(MAC, SRCA, 16'h05FF, 0, 8'hA0, 1'b1);
    frame(MAC, SRCA, 16'h0600, 2, 8'hB0, 1'b1);
    chk_cnt("t8", 2, 0, 2, 3);
    snap();
    frame(MAC, SRCA, 16'd1500, 1502, 8'h00, 1'b1);
    chk_cnt("t9", 1500, 1, 0, 1);
    snap();
    frame(BC, SRCA, 16'h0001, 2, 8'hE0, 1'b1);
    chk_cnt("t10", 1, 1, 0, 1);
    sfd();
    for (int i = 0; i < 6; i++) hdr_byte(0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) hdr_byte(1, 8'(8'h50 + i));
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    bus.i_enable = 1'b0;
    bus.i_data = 8'h00;
    bus.i_src_addr_valid = 1'b0;
    cur = '0;
    nx = '0;
    pend_fe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snap();
    frame(MAC, SRCA, 16'h0800, 2, 8'hF0, 1'b1);
    chk("t11_dst", 64'(bus.o_dst_addr), 64'h010203040506);
    chk_cnt("t11", 2, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
